merge_out_fifo: RTL and testbench

Output buffer placed directly downstream of `merge_switch_seq`. It captures the merged valid/data stream into a circular FIFO and presents it to the next NoC stage through a valid/ready handshake. It drives a throttle signal back to the merge switch's `i_en` so that no merged word is lost when the consumer stalls. It also flags any word that arrives while the buffer is full.

---
 rtl/merge_out_fifo.sv | 90 +++++++++
 tb/tb_merge_out_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/merge_out_fifo.sv
// Output FIFO behind merge_switch_seq: first-word fall-through buffer with a throttle back to the
// merge switch. Optional drop counter is enabled with `define MERGE_OUT_FIFO_DROP_CNT_EN.
module merge_out_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SLACK      = 2,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data_bus,
  output logic                  o_en_merge,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  input  logic                  i_ready,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [15:0]           o_drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && i_ready;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign w_push  = i_valid && (!w_full || w_pop);
  assign w_drop  = i_valid && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data_bus;
  end

  assign o_valid    = !w_empty;
  assign o_data_bus = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  // SLACK entries stay free for words already in flight from the merge switch.
  assign o_en_merge = (r_count <= CNT_W'(DEPTH - SLACK - 1));

`ifdef MERGE_OUT_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
  assign o_drop_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_merge_out_fifo.sv
// Bench for merge_out_fifo: table-driven vectors with a data scoreboard, plus hand-written
// reset sequences.
module tb_merge_out_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SLACK = 2;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [DW-1:0] i_data_bus;
  logic          o_en_merge;
  logic          o_valid;
  logic [DW-1:0] o_data_bus;
  logic          i_ready;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;
  logic [15:0]   o_drop_cnt;

  merge_out_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .SLACK     (SLACK),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_data_bus(i_data_bus),
    .o_en_merge(o_en_merge),
    .o_valid   (o_valid),
    .o_data_bus(o_data_bus),
    .i_ready   (i_ready),
    .o_count   (o_count),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  // cnt is the occupancy expected during the cycle the vector is applied (before the edge).
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    int            cnt;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  int            n_vec     = 0;
  int            n_err     = 0;
  int            exp_drops = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [DW-1:0] d, input logic r, input int cnt);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  function automatic logic [15:0] exp_drop_val();
`ifdef MERGE_OUT_FIFO_DROP_CNT_EN
    return 16'(exp_drops);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic apply(input vec_t t, input string tag);
    logic [DW-1:0] exp_d;
    @(negedge clk);
    i_valid    = t.v;
    i_data_bus = t.d;
    i_ready    = t.r;
    #1;
    chk({tag, " count"}, DW'(o_count), DW'(t.cnt));
    chk({tag, " en_merge"}, DW'(o_en_merge), DW'(t.cnt <= DEPTH - SLACK - 1));
    chk({tag, " full"}, DW'(o_full), DW'(t.cnt == DEPTH));
    chk({tag, " empty"}, DW'(o_empty), DW'(t.cnt == 0));
    chk({tag, " valid"}, DW'(o_valid), DW'(t.cnt != 0));
    chk({tag, " drop_cnt"}, DW'(o_drop_cnt), DW'(exp_drop_val()));
    if (t.r && t.cnt != 0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s data: got %h, expected nothing (scoreboard empty)", tag, o_data_bus);
      end else begin
        exp_d = sb.pop_front();
        chk({tag, " data"}, o_data_bus, exp_d);
      end
    end
    if (t.v && (t.cnt < DEPTH || (t.r && t.cnt != 0))) sb.push_back(t.d);
    else if (t.v) exp_drops++;
  endtask

  initial begin
    rst        = 1'b0;
    i_valid    = 1'b1;
    i_data_bus = 32'hFFFF_FFFF;
    i_ready    = 1'b0;

    // Reset held with i_valid asserted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst valid", DW'(o_valid), 0);
      chk("rst count", DW'(o_count), 0);
      chk("rst en_merge", DW'(o_en_merge), 1);
      chk("rst drop_cnt", DW'(o_drop_cnt), 0);
      chk("rst empty", DW'(o_empty), 1);
      chk("rst full", DW'(o_full), 0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b1;

    // Fill, idle at full, overflow, drain.
    for (int i = 0; i < 8; i++) add(1'b1, 32'hA000_0000 + DW'(i), 1'b0, i);
    add(1'b0, '0, 1'b0, 8);
    for (int i = 0; i < 3; i++) add(1'b1, 32'hDEAD_0000 + DW'(i), 1'b0, 8);
    for (int i = 0; i < 8; i++) add(1'b0, '0, 1'b1, 8 - i);
    add(1'b0, '0, 1'b0, 0);
    // Refill, then push and pop together at full.
    for (int i = 0; i < 8; i++) add(1'b1, 32'h1000_0000 + DW'(i), 1'b0, i);
    add(1'b1, 32'hBBBB_BBBB, 1'b1, 8);
    add(1'b0, '0, 1'b0, 8);
    for (int i = 0; i < 8; i++) add(1'b0, '0, 1'b1, 8 - i);
    // Push with ready at empty: nothing to pop, word appears after the edge.
    add(1'b1, 32'h5555_AAAA, 1'b1, 0);
    add(1'b0, '0, 1'b1, 1);
    add(1'b0, '0, 1'b0, 0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Mid-stream asynchronous reset with 5 words buffered.
    for (int i = 0; i < 5; i++) begin
      vec_t t;
      t.v = 1'b1; t.d = 32'h3000_0000 + DW'(i); t.r = 1'b0; t.cnt = i;
      apply(t, $sformatf("m%0d", i));
    end
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("mid pre count", DW'(o_count), 5);
    #2;
    rst = 1'b0;
    #1;
    chk("mid rst valid", DW'(o_valid), 0);
    chk("mid rst count", DW'(o_count), 0);
    chk("mid rst empty", DW'(o_empty), 1);
    chk("mid rst en_merge", DW'(o_en_merge), 1);
    sb.delete();
    exp_drops = 0;
    @(negedge clk);
    rst = 1'b1;
    begin
      vec_t t;
      t.v = 1'b1; t.d = 32'hCCCC_CCCC; t.r = 1'b0; t.cnt = 0;
      apply(t, "post0");
      t.v = 1'b0; t.d = '0; t.r = 1'b1; t.cnt = 1;
      apply(t, "post1");
      t.v = 1'b0; t.d = '0; t.r = 1'b0; t.cnt = 0;
      apply(t, "post2");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
